video_frame_crc: RTL and testbench
==================================

Name: video_frame_crc

Overview:
- Synthesizable, parametrised video frame signature unit. It is the in-fabric successor to the simulation-only pixel dump used for render checking.
- Taps the epochtv1 video output (CE/DE/HS/VS/RGB). Computes a CRC-32 over active pixels per frame, and optionally per line.
- Measures active width and height, and flags irregular line widths.
- Results are latched once per frame, so a bench or on-target debug host can compare them against golden values without storing pixels.

Parameters:
- RGB_W, 24: pixel width in bits (1..32).
- LINE_AW, 8: line counter / line-buffer address width. Max stored lines = 2^LINE_AW.
- CNT_W, 10: width of the pixel-per-line counter.

Ports:
- CLK  in  1  system clock
- RES  in  1  asynchronous active-high reset
- CE  in  1  pixel clock enable; all video inputs are sampled only when CE=1
- DE  in  1  active-pixel enable
- HS  in  1  horizontal sync (ignored except by the optional feature)
- VS  in  1  vertical sync, active-high
- RGB  in  RGB_W  pixel data
- FRAME_CRC  out  32  CRC of the last completed frame
- ACT_W  out  CNT_W  pixel count of the first line of the last frame
- ACT_H  out  LINE_AW+1  active line count of the last frame (saturating)
- LINE_ERR  out  1  last frame had a line whose width differed from line 0
- OVF  out  1  last frame exceeded 2^LINE_AW lines
- FRAME_VALID  out  1  one-CLK pulse when the outputs above update
- LA  in  LINE_AW  line CRC read address (optional feature)
- LCRC  out  32  line CRC read data (optional feature)

Behaviour:
- Reset: all outputs are 0. FRAME_CRC is 0, not the init value. The FSM enters SYNC.
- CRC: polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection, no final XOR. One pixel is folded per CE with DE=1, RGB_W bits MSB first, in a single cycle.
- Edge detection uses registered DE and VS, updated only on CE cycles. "DE fall" means prev=1, now=0. "VS rise" means prev=0, now=1.
- FSM states:
  - SYNC: wait for a VS rise. Pixels are ignored. On a VS rise: clear the accumulators and go to RUN. No FRAME_VALID is issued, because the first partial frame after reset is discarded.
  - RUN: accumulate. On a VS rise:
    - latch FRAME_CRC, ACT_W, ACT_H, LINE_ERR and OVF;
    - pulse FRAME_VALID in the following CLK cycle;
    - clear the accumulators and stay in RUN.
- Accumulators:
  - frame CRC;
  - pixel counter (CNT_W, saturating at max);
  - line counter (LINE_AW+1 bits, saturating);
  - reference width;
  - error and overflow bits.
- Line end happens on a DE fall:
  - line 0: the reference width is set to the pixel count;
  - line n>0: if the count differs from the reference width, set the error bit;
  - then increment the line counter and clear the pixel counter.
- OVF is set when a line end occurs with the line counter already equal to 2^LINE_AW.
- Simultaneous events:
  - VS rise with DE=1 on the same CE: that pixel belongs to the new frame. Latch first, then fold the pixel into the cleared CRC.
  - DE fall coinciding with a VS rise: the line end is applied to the outgoing frame before latching.
- A frame containing no DE pixels latches FRAME_CRC=0xFFFFFFFF, ACT_W=0, ACT_H=0.
- A line still open at the VS rise (DE=1 at VS) is not counted as a line. Its pixels are still in the CRC.
- Latency: FRAME_VALID is asserted 1 CLK after the CE sampling the VS rise. Outputs are stable until the next latch.
- Reset mid-frame: immediate clear, return to SYNC.

Optional Feature:
- VIDEO_FRAME_CRC_LINE_BUF_EN, defined:
  - keep a per-line CRC, initialised to 0xFFFFFFFF at each line start;
  - on each line end, write it to a 2^LINE_AW x 32 RAM at the line index;
  - lines beyond the RAM size are not written;
  - the RAM is double-buffered and swaps bank on the VS-rise latch;
  - LA reads the bank from the last completed frame, with 1-CLK synchronous read latency;
  - an HS rise with DE=1 also forces a line end (sets LINE_ERR).
- Undefined:
  - no RAM and no line CRC;
  - LCRC ties to 0 and LA is ignored;
  - HS is unused.

Test Plan:
- Reset, then VS pulses with no DE -> FRAME_VALID only from the 2nd VS rise on; FRAME_CRC=0xFFFFFFFF, ACT_W=0, ACT_H=0, all flags 0.
- 3 lines x 4 pixels RGB=0x000000..0x00000B, CE every 7 CLK -> ACT_W=4, ACT_H=3, LINE_ERR=0; FRAME_CRC matches the bench software model.
- Line widths 4,4,5 -> LINE_ERR=1, ACT_W=4, ACT_H=3; next clean frame -> LINE_ERR=0.
- LINE_AW=2, frame of 6 lines -> ACT_H=6, OVF=1; with LINE_BUF_EN, LA=0..3 returns the model CRCs of lines 0..3 one CLK after LA is applied.
- RES asserted mid-frame -> outputs 0 immediately; the next VS rise produces no FRAME_VALID; the following frame is correct.
- VS rise coincident with DE=1 pixel 0x123456 -> that pixel is excluded from the old CRC and included in the new frame's CRC.

Source files
------------

// File: rtl/video_frame_crc.sv
// Frame signature unit: CRC-32 over active pixels, active width/height and line-width checks.
// Define VIDEO_FRAME_CRC_LINE_BUF_EN to add the double-buffered per-line CRC RAM (LA/LCRC, HS line ends).
module video_frame_crc #(
  parameter int unsigned RGB_W   = 24,
  parameter int unsigned LINE_AW = 8,
  parameter int unsigned CNT_W   = 10
) (
  input  logic               CLK,
  input  logic               RES,
  input  logic               CE,
  input  logic               DE,
  input  logic               HS,
  input  logic               VS,
  input  logic [RGB_W-1:0]   RGB,
  output logic [31:0]        FRAME_CRC,
  output logic [CNT_W-1:0]   ACT_W,
  output logic [LINE_AW:0]   ACT_H,
  output logic               LINE_ERR,
  output logic               OVF,
  output logic               FRAME_VALID,
  input  logic [LINE_AW-1:0] LA,
  output logic [31:0]        LCRC
);

  localparam int unsigned      LC_W      = LINE_AW + 1;
  localparam logic [31:0]      CRC_POLY  = 32'h04C11DB7;
  localparam logic [31:0]      CRC_INIT  = 32'hFFFFFFFF;
  localparam logic [LC_W-1:0]  LINES_MAX = {1'b1, {LINE_AW{1'b0}}};
  localparam logic [LC_W-1:0]  LINE_SAT  = '1;
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  typedef enum logic [0:0] {
    ST_SYNC,
    ST_RUN
  } state_t;

  // Bit-serial fold of one pixel, MSB first, non-reflected
  function automatic logic [31:0] crc_fold(input logic [31:0] crc, input logic [RGB_W-1:0] px);
    logic [31:0]      c;
    logic [RGB_W-1:0] d;
    logic             fb;
    c = crc;
    d = px;
    for (int unsigned i = 0; i < RGB_W; i++) begin
      fb = c[31] ^ d[RGB_W-1];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
      d  = {d[RGB_W-2:0], 1'b0};
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic             de_q, de_d;
  logic             vs_q, vs_d;
  logic [31:0]      crc_q, crc_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [LC_W-1:0]  line_q, line_d;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      fcrc_q, fcrc_d;
  logic [CNT_W-1:0] actw_q, actw_d;
  logic [LC_W-1:0]  acth_q, acth_d;
  logic             lerr_q, lerr_d;
  logic             fovf_q, fovf_d;
  logic             valid_q, valid_d;

  logic vs_rise_c;
  logic de_fall_c;
  logic hs_force_c;
  logic line_end_c;
  logic pix_fold_c;

  assign vs_rise_c  = CE & ~vs_q & VS;
  assign de_fall_c  = CE & de_q & ~DE;
  assign line_end_c = (state_q == ST_RUN) & (de_fall_c | hs_force_c);
  assign pix_fold_c = CE & DE & ((state_q == ST_RUN) | vs_rise_c);

  // Line end is applied to the outgoing frame, then the latch, then the pixel of this CE
  always_comb begin
    state_d = state_q;
    de_d    = de_q;
    vs_d    = vs_q;
    crc_d   = crc_q;
    pix_d   = pix_q;
    line_d  = line_q;
    ref_d   = ref_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    fcrc_d  = fcrc_q;
    actw_d  = actw_q;
    acth_d  = acth_q;
    lerr_d  = lerr_q;
    fovf_d  = fovf_q;
    valid_d = 1'b0;

    if (CE) begin
      de_d = DE;
      vs_d = VS;
    end

    if (line_end_c) begin
      if (line_q == '0) begin
        ref_d = pix_q;
      end else if (pix_q != ref_q) begin
        err_d = 1'b1;
      end
      if (hs_force_c) begin
        err_d = 1'b1;
      end
      if (line_q == LINES_MAX) begin
        ovf_d = 1'b1;
      end
      if (line_q != LINE_SAT) begin
        line_d = line_q + LC_W'(1);
      end
      pix_d = '0;
    end

    if (vs_rise_c) begin
      if (state_q == ST_RUN) begin
        fcrc_d  = crc_q;
        actw_d  = ref_d;
        acth_d  = line_d;
        lerr_d  = err_d;
        fovf_d  = ovf_d;
        valid_d = 1'b1;
      end
      state_d = ST_RUN;
      crc_d   = CRC_INIT;
      pix_d   = '0;
      line_d  = '0;
      ref_d   = '0;
      err_d   = 1'b0;
      ovf_d   = 1'b0;
    end

    if (pix_fold_c) begin
      crc_d = crc_fold(crc_d, RGB);
      if (pix_d != CNT_SAT) begin
        pix_d = pix_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= ST_SYNC;
      de_q    <= 1'b0;
      vs_q    <= 1'b0;
      crc_q   <= CRC_INIT;
      pix_q   <= '0;
      line_q  <= '0;
      ref_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      fcrc_q  <= '0;
      actw_q  <= '0;
      acth_q  <= '0;
      lerr_q  <= 1'b0;
      fovf_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      de_q    <= de_d;
      vs_q    <= vs_d;
      crc_q   <= crc_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      ref_q   <= ref_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      fcrc_q  <= fcrc_d;
      actw_q  <= actw_d;
      acth_q  <= acth_d;
      lerr_q  <= lerr_d;
      fovf_q  <= fovf_d;
      valid_q <= valid_d;
    end
  end

  assign FRAME_CRC   = fcrc_q;
  assign ACT_W       = actw_q;
  assign ACT_H       = acth_q;
  assign LINE_ERR    = lerr_q;
  assign OVF         = fovf_q;
  assign FRAME_VALID = valid_q;

`ifdef VIDEO_FRAME_CRC_LINE_BUF_EN
  localparam int unsigned DEPTH = 2 ** LC_W;

  logic        hs_q;
  logic        bank_q, bank_d;
  logic [31:0] lacc_q, lacc_d;
  logic [31:0] rd_q;
  logic [31:0] ram_q [DEPTH];
  logic        ram_we_c;

  assign hs_force_c = CE & ~hs_q & HS & DE;
  assign ram_we_c   = line_end_c & ~line_q[LINE_AW];

  // Per-line CRC restarts at every line end and frame start
  always_comb begin
    lacc_d = lacc_q;
    bank_d = bank_q;
    if (line_end_c) begin
      lacc_d = CRC_INIT;
    end
    if (vs_rise_c) begin
      lacc_d = CRC_INIT;
      if (state_q == ST_RUN) begin
        bank_d = ~bank_q;
      end
    end
    if (pix_fold_c) begin
      lacc_d = crc_fold(lacc_d, RGB);
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      hs_q   <= 1'b0;
      bank_q <= 1'b0;
      lacc_q <= CRC_INIT;
      rd_q   <= '0;
    end else begin
      if (CE) begin
        hs_q <= HS;
      end
      bank_q <= bank_d;
      lacc_q <= lacc_d;
      rd_q   <= ram_q[{~bank_q, LA}];
    end
  end

  always_ff @(posedge CLK) begin
    if (ram_we_c) begin
      ram_q[{bank_q, line_q[LINE_AW-1:0]}] <= lacc_q;
    end
  end

  assign LCRC = rd_q;
`else
  logic unused_line_buf;

  assign hs_force_c      = 1'b0;
  assign unused_line_buf = ^{HS, LA};
  assign LCRC            = '0;
`endif

endmodule

// File: tb/tb_video_frame_crc.sv
// Directed bench for video_frame_crc (LINE_AW=2) with a byte-wise CRC-32/MPEG-2 reference.
module tb_video_frame_crc;

  localparam int unsigned RGB_W   = 24;
  localparam int unsigned LINE_AW = 2;
  localparam int unsigned CNT_W   = 10;
  localparam logic [31:0] INIT    = 32'hFFFFFFFF;

  logic               CLK = 1'b0;
  logic               RES;
  logic               CE;
  logic               DE;
  logic               HS;
  logic               VS;
  logic [RGB_W-1:0]   RGB;
  logic [31:0]        FRAME_CRC;
  logic [CNT_W-1:0]   ACT_W;
  logic [LINE_AW:0]   ACT_H;
  logic               LINE_ERR;
  logic               OVF;
  logic               FRAME_VALID;
  logic [LINE_AW-1:0] LA;
  logic [31:0]        LCRC;

  int n_cmp   = 0;
  int n_err   = 0;
  int n_valid = 0;

  video_frame_crc #(.RGB_W(RGB_W), .LINE_AW(LINE_AW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RES(RES), .CE(CE), .DE(DE), .HS(HS), .VS(VS), .RGB(RGB),
    .FRAME_CRC(FRAME_CRC), .ACT_W(ACT_W), .ACT_H(ACT_H), .LINE_ERR(LINE_ERR),
    .OVF(OVF), .FRAME_VALID(FRAME_VALID), .LA(LA), .LCRC(LCRC)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (FRAME_VALID) n_valid++;

  function automatic logic [31:0] m_fold(input logic [31:0] crc, input logic [23:0] px);
    logic [31:0] c;
    logic [7:0]  by;
    c = crc;
    for (int b = 2; b >= 0; b--) begin
      by = px[b*8 +: 8];
      c  = c ^ {by, 24'h0};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One CE sample every 7 CLK; returns 1 ns after the edge following the CE edge
  task automatic step(input logic de, input logic vs, input logic [23:0] px);
    repeat (6) @(posedge CLK);
    #1;
    CE = 1'b1; DE = de; VS = vs; RGB = px;
    @(posedge CLK);
    #1;
    CE = 1'b0;
  endtask

  task automatic vs_rise(input logic de, input logic [23:0] px, input logic exp_v);
    step(de, 1'b1, px);
    chk("frame_valid", {31'h0, FRAME_VALID}, {31'h0, exp_v});
    @(posedge CLK);
    #1;
    chk("frame_valid_drop", {31'h0, FRAME_VALID}, 32'h0);
  endtask

  logic [31:0] e;
  logic [31:0] el [4];
  logic [23:0] px;
  int          nv;

  initial begin
    RES = 1'b1; CE = 1'b0; DE = 1'b0; HS = 1'b0; VS = 1'b0; RGB = '0; LA = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_crc", FRAME_CRC, 32'h0);
    chk("rst_w", 32'(ACT_W), 32'h0);
    chk("rst_h", 32'(ACT_H), 32'h0);
    chk("rst_err", {31'h0, LINE_ERR}, 32'h0);
    chk("rst_ovf", {31'h0, OVF}, 32'h0);
    chk("rst_valid", {31'h0, FRAME_VALID}, 32'h0);
    chk("rst_lcrc", LCRC, 32'h0);
    RES = 1'b0;

    // Empty frames: first VS rise only arms the unit
    vs_rise(1'b0, 24'h0, 1'b0);
    chk("sync_no_valid", n_valid, 0);
    step(1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b0, 24'h0);
    vs_rise(1'b0, 24'h0, 1'b1);
    chk("empty_crc", FRAME_CRC, INIT);
    chk("empty_w", 32'(ACT_W), 32'd0);
    chk("empty_h", 32'(ACT_H), 32'd0);
    chk("empty_err", {31'h0, LINE_ERR}, 32'h0);
    chk("empty_ovf", {31'h0, OVF}, 32'h0);
    chk("empty_valid_cnt", n_valid, 1);

    // 3 lines x 4 pixels, RGB 0..11
    e = INIT;
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < 4; p++) begin
        px = 24'(l * 4 + p);
        step(1'b1, 1'b0, px);
        e = m_fold(e, px);
      end
      step(1'b0, 1'b0, 24'h0);
    end
    vs_rise(1'b0, 24'h0, 1'b1);
    chk("f3x4_crc", FRAME_CRC, e);
    chk("f3x4_w", 32'(ACT_W), 32'd4);
    chk("f3x4_h", 32'(ACT_H), 32'd3);
    chk("f3x4_err", {31'h0, LINE_ERR}, 32'h0);
    chk("f3x4_ovf", {31'h0, OVF}, 32'h0);

    // Widths 4,4,5
    e = INIT;
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < ((l == 2) ? 5 : 4); p++) begin
        px = 24'h000100 + 24'(l * 8 + p);
        step(1'b1, 1'b0, px);
        e = m_fold(e, px);
      end
      step(1'b0, 1'b0, 24'h0);
    end
    vs_rise(1'b0, 24'h0, 1'b1);
    chk("ragged_crc", FRAME_CRC, e);
    chk("ragged_w", 32'(ACT_W), 32'd4);
    chk("ragged_h", 32'(ACT_H), 32'd3);
    chk("ragged_err", {31'h0, LINE_ERR}, 32'h1);

    // Clean frame after the ragged one
    e = INIT;
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < 4; p++) begin
        px = 24'hC0FF00 ^ 24'(l * 37 + p * 5);
        step(1'b1, 1'b0, px);
        e = m_fold(e, px);
      end
      step(1'b0, 1'b0, 24'h0);
    end
    vs_rise(1'b0, 24'h0, 1'b1);
    chk("clean_crc", FRAME_CRC, e);
    chk("clean_err", {31'h0, LINE_ERR}, 32'h0);

    // 6 lines x 2 pixels with only 4 line slots
    e = INIT;
    for (int l = 0; l < 6; l++) begin
      if (l < 4) el[l] = INIT;
      for (int p = 0; p < 2; p++) begin
        px = 24'h030000 + 24'(l * 16 + p);
        step(1'b1, 1'b0, px);
        e = m_fold(e, px);
        if (l < 4) el[l] = m_fold(el[l], px);
      end
      step(1'b0, 1'b0, 24'h0);
    end
    vs_rise(1'b0, 24'h0, 1'b1);
    chk("ovf_crc", FRAME_CRC, e);
    chk("ovf_w", 32'(ACT_W), 32'd2);
    chk("ovf_h", 32'(ACT_H), 32'd6);
    chk("ovf_flag", {31'h0, OVF}, 32'h1);
    chk("ovf_err", {31'h0, LINE_ERR}, 32'h0);
`ifdef VIDEO_FRAME_CRC_LINE_BUF_EN
    for (int i = 0; i < 4; i++) begin
      LA = 2'(i);
      @(posedge CLK);
      #1;
      chk($sformatf("lcrc_%0d", i), LCRC, el[i]);
    end
`endif

    // Reset in the middle of a frame
    step(1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 24'hAAAAAA);
    step(1'b1, 1'b0, 24'h555555);
    #2;
    RES = 1'b1;
    #1;
    chk("midrst_crc", FRAME_CRC, 32'h0);
    chk("midrst_w", 32'(ACT_W), 32'h0);
    chk("midrst_h", 32'(ACT_H), 32'h0);
    chk("midrst_ovf", {31'h0, OVF}, 32'h0);
    chk("midrst_lcrc", LCRC, 32'h0);
    @(posedge CLK);
    #1;
    RES = 1'b0;
    DE  = 1'b0;
    nv  = n_valid;
    vs_rise(1'b0, 24'h0, 1'b0);
    chk("midrst_no_valid", n_valid, nv);
    step(1'b0, 1'b0, 24'h0);
    e = INIT;
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 3; p++) begin
        px = 24'h7E0000 + 24'(l * 256 + p * 3);
        step(1'b1, 1'b0, px);
        e = m_fold(e, px);
      end
      step(1'b0, 1'b0, 24'h0);
    end
    vs_rise(1'b0, 24'h0, 1'b1);
    chk("postrst_crc", FRAME_CRC, e);
    chk("postrst_w", 32'(ACT_W), 32'd3);
    chk("postrst_h", 32'(ACT_H), 32'd2);
    chk("postrst_ovf", {31'h0, OVF}, 32'h0);

    // VS rise coincident with an active pixel
    step(1'b0, 1'b0, 24'h0);
    e = INIT;
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 3; p++) begin
        px = 24'h000040 + 24'(l * 3 + p);
        step(1'b1, 1'b0, px);
        e = m_fold(e, px);
      end
      step(1'b0, 1'b0, 24'h0);
    end
    vs_rise(1'b1, 24'h123456, 1'b1);
    chk("coinc_old_crc", FRAME_CRC, e);
    chk("coinc_old_h", 32'(ACT_H), 32'd2);
    step(1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 24'hABCDEF);
    step(1'b0, 1'b0, 24'h0);
    vs_rise(1'b0, 24'h0, 1'b1);
    chk("coinc_new_crc", FRAME_CRC, m_fold(m_fold(INIT, 24'h123456), 24'hABCDEF));
    chk("coinc_new_w", 32'(ACT_W), 32'd1);
    chk("coinc_new_h", 32'(ACT_H), 32'd2);
    chk("coinc_new_err", {31'h0, LINE_ERR}, 32'h0);
    chk("valid_total", n_valid, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
